aludec_seq: RTL

//   Registered, handshaked ALU decoder for the 16-bit RISC datapath; successor to the combinational decoder.

---
 rtl/aludec_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aludec_seq.sv
// Registered, valid/ready ALU decoder with a multi-cycle MUL execute stall.
// Optional ALUDEC_SEQ_ILLEGAL_EN adds a registered 'illegal' flag for unknown op/funct.
module aludec_seq #(
    parameter int unsigned OP_W       = 4,
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_control,
    output logic               busy
`ifdef ALUDEC_SEQ_ILLEGAL_EN
    ,
    output logic               illegal
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES) + 1;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_NOR  = 4'b0011;
    localparam logic [3:0] C_XOR  = 4'b0100;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MUL  = 4'b1001;
    localparam logic [3:0] C_SLL  = 4'b1010;
    localparam logic [3:0] C_SRL  = 4'b1101;
    localparam logic [3:0] C_SLTU = 4'b1110;
    localparam logic [3:0] C_SRA  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               out_valid_q, busy_q;
    logic               accept, load;
    logic [3:0]         dec_code;
    logic               dec_unk, dec_mul;

    // Pure decode of the incoming op/funct; unknown encodings fall back to ADD.
    always_comb begin
        dec_code = C_ADD;
        dec_unk  = 1'b0;
        dec_mul  = 1'b0;
        if (op == '0) begin
            if (|(funct >> 6)) begin
                dec_unk = 1'b1;
            end else begin
                case (funct[5:0])
                    6'b100100: dec_code = C_AND;
                    6'b100101: dec_code = C_OR;
                    6'b100000: dec_code = C_ADD;
                    6'b100010: dec_code = C_SUB;
                    6'b101010: dec_code = C_SLT;
                    6'b100111: dec_code = C_NOR;
                    6'b011000: begin
                        dec_code = C_MUL;
                        dec_mul  = 1'b1;
                    end
                    6'b000000: dec_code = C_SLL;
                    6'b000010: dec_code = C_SRL;
                    6'b100110: dec_code = C_XOR;
                    6'b101011: dec_code = C_SLTU;
                    6'b000011: dec_code = C_SRA;
                    default:   dec_unk  = 1'b1;
                endcase
            end
        end else begin
            case (op)
                OP_W'(1): dec_code = C_ADD;
                OP_W'(2): dec_code = C_AND;
                OP_W'(3): dec_code = C_OR;
                OP_W'(4): dec_code = C_SLT;
                OP_W'(5): dec_code = C_ADD;
                OP_W'(6): dec_code = C_ADD;
                OP_W'(7): dec_code = C_SUB;
                OP_W'(8): dec_code = C_XOR;
                default:  dec_unk  = 1'b1;
            endcase
        end
    end

    assign in_ready = ~reset & ((state_q == S_IDLE) | ((state_q == S_VALID) & out_ready));
    assign accept   = in_valid & in_ready;

    // Next-state: load on accept, count down MUL, drain on out_ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: load = accept;
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_VALID;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_VALID: begin
                if (out_ready) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            ctrl_d = CTRL_W'(dec_code);
            if (dec_mul && (MUL_CYCLES > 1)) begin
                state_d = S_EXEC;
                cnt_d   = CNT_W'(MUL_CYCLES - 2);
            end else begin
                state_d = S_VALID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ctrl_q      <= CTRL_W'(C_ADD);
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= (state_d == S_VALID);
            busy_q      <= (state_d == S_EXEC);
        end
    end

    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign alu_control = ctrl_q;

`ifdef ALUDEC_SEQ_ILLEGAL_EN
    logic ill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ill_q <= 1'b0;
        end else if (load) begin
            ill_q <= dec_unk;
        end
    end

    assign illegal = ill_q;
`else
    logic unused_dec_unk;
    assign unused_dec_unk = dec_unk;
`endif

endmodule
